// File: rtl/byte_serial_adder_ctrl.sv
// Sequences a 32-bit add/subtract through a shared external 8-bit adder slice,
// one byte per cycle, least-significant byte first.
//
// state | meaning
// IDLE  | waiting for start; slice inputs held at zero
// RUN   | driving byte idx_q to the slice and capturing its result
// DONE  | one-cycle result-valid pulse
module byte_serial_adder_ctrl (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        sub_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [7:0]  add_a_o,
  output logic [7:0]  add_b_o,
  output logic        add_cin_o,
  input  logic [7:0]  add_sum_i,
  input  logic        add_cout_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] sum_o,
  output logic        carry_out_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sub_q, sub_d;
  logic        carry_q, carry_d;
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= 32'd0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    add_a_o   = 8'd0;
    add_b_o   = 8'd0;
    add_cin_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          a_d     = op_a_i;
          // Subtract as A + ~B + 1; the +1 enters as the byte-0 carry-in.
          b_d     = sub_i ? ~op_b_i : op_b_i;
          sub_d   = sub_i;
          idx_d   = 2'd0;
        end
      end
      RUN: begin
        add_a_o   = a_q[{idx_q, 3'b000} +: 8];
        add_b_o   = b_q[{idx_q, 3'b000} +: 8];
        add_cin_o = (idx_q == 2'd0) ? sub_q : carry_q;
        sum_d[{idx_q, 3'b000} +: 8] = add_sum_i;
        carry_d   = add_cout_i;
        idx_d     = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
          cout_d  = add_cout_i;
          ovf_d   = (a_q[31] == b_q[31]) && (add_sum_i[7] != a_q[31]);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign sum_o       = sum_q;
  assign carry_out_o = cout_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Bench for byte_serial_adder_ctrl: behavioural 8-bit slice, vector table,
// scoreboard popped on done, plus abort and busy-ignore sequences.
module tb_byte_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        busy, done, carry_out, overflow;
  logic [31:0] sum;

  always #5 clk = ~clk;

  // External slice: purely combinational 8-bit adder.
  logic [8:0] slice_full;
  assign slice_full = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign add_sum    = slice_full[7:0];
  assign add_cout   = slice_full[8];

  byte_serial_adder_ctrl dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .sub_i(sub),
    .op_a_i(op_a), .op_b_i(op_b),
    .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
    .add_sum_i(add_sum), .add_cout_i(add_cout),
    .busy_o(busy), .done_o(done), .sum_o(sum),
    .carry_out_o(carry_out), .overflow_o(overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] exp_sum;
    logic        exp_c;
    logic        exp_v;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  logic [7:0] a_tr [4];
  logic [7:0] b_tr [4];
  logic       cin_tr [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    logic [31:0] be;
    logic [32:0] r;
    be  = s ? ~b : b;
    r   = {1'b0, a} + {1'b0, be} + {32'd0, s};
    e.sum = r[31:0];
    e.c   = r[32];
    e.v   = (a[31] == be[31]) && (r[31] != a[31]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("carry_out", {31'd0, carry_out}, {31'd0, e.c});
        check("overflow", {31'd0, overflow}, {31'd0, e.v});
      end
    end
  end

  // Drives one operation from IDLE; records the four byte-cycle slice inputs
  // and checks that done arrives in the 5th cycle after driving start
  // (4 cycles after the accept edge).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input exp_t e);
    int n = 0;
    bit got = 0;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    sb.push_back(e);
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) check("busy_after_accept", {31'd0, busy}, 32'd1);
      if (n <= 4) begin
        a_tr[n-1] = add_a; b_tr[n-1] = add_b; cin_tr[n-1] = add_cin;
      end
      if (done) got = 1;
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    check("done_latency", n, 5);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_width", {31'd0, done}, 32'd0);
  endtask

  vec_t tbl [8];

  initial begin
    exp_t e;
    int   d0;
    bit   got;
    logic [31:0] ra, rb, keep;

    tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
    check("rst_slice", {15'd0, add_a, add_b, add_cin}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      e.sum = tbl[i].exp_sum; e.c = tbl[i].exp_c; e.v = tbl[i].exp_v;
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, e);
      if (i == 0) begin
        check("v0_byte0_a", {24'd0, a_tr[0]}, 32'hFF);
        check("v0_byte0_cin", {31'd0, cin_tr[0]}, 32'd0);
        check("v0_byte1_cin", {31'd0, cin_tr[1]}, 32'd1);
      end
      if (i == 3) begin
        check("sub_byte0_b", {24'd0, b_tr[0]}, 32'hF8);
        check("sub_byte0_cin", {31'd0, cin_tr[0]}, 32'd1);
        check("sub_byte3_b", {24'd0, b_tr[3]}, 32'hFF);
      end
    end

    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom;
      e = model(ra, rb, i[0]);
      run_op(ra, rb, i[0], e);
    end

    // Extra starts during RUN and DONE must be ignored.
    d0 = n_done;
    e = model(32'h0102_0304, 32'h1111_1111, 1'b0);
    keep = e.sum;
    @(negedge clk);
    op_a = 32'h0102_0304; op_b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    sb.push_back(e);
    @(negedge clk); start = 1'b0;
    @(negedge clk); op_a = 32'hDEAD_BEEF; op_b = 32'h5555_5555; sub = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    if (!got) check("ignore_done_timeout", 32'd0, 32'd1);
    op_a = 32'hCAFE_F00D; op_b = 32'h0F0F_0F0F; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("ignore_idle", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("ignore_sum_held", sum, keep);
    check("ignore_one_done", n_done - d0, 1);
    e = model(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, e);

    // Reset while byte 2 is on the slice aborts with no done.
    @(negedge clk);
    op_a = 32'h00FF_FFFF; op_b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", sum, 32'd0);
    check("abort_slice", {15'd0, add_a, add_b, add_cin}, 32'd0);
    reset = 1'b0;
    d0 = n_done;
    repeat (8) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    e = model(32'h00FF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, e);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
